nr_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit nanoRisk RAM (write port: in/adrin/canWr; read port: adrout/canRd/out). Instruction-fetch port is read-only; data (load/store) port reads or writes. The block serializes accesses with round-robin fairness, drives RAM strobes for exactly the access duration, and returns a one-cycle ack with registered read data.

---
 rtl/nr_mem_pkg.sv | 17 +
 rtl/nr_rr_pick2.sv | 19 +
 rtl/nr_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_nr_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nr_mem_pkg.sv
// rtl/nr_mem_pkg.sv - shared types and constants for the nanoRisk RAM arbiter
package nr_mem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/nr_rr_pick2.sv
// rtl/nr_rr_pick2.sv - combinational two-way round-robin pick
module nr_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid,
  output logic conflict
);

  always_comb begin
    valid    = req0 | req1;
    conflict = req0 & req1;
    // On a tie the requester that did not win last time goes first
    if (conflict) gnt = ~last;
    else          gnt = req1;
  end

endmodule

// File: rtl/nr_mem_arbiter.sv
// rtl/nr_mem_arbiter.sv - fetch/data arbiter and access sequencer for the shared RAM
module nr_mem_arbiter
  import nr_mem_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          f_req,
  input  logic [AW-1:0] f_adr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [DW-1:0] mem_in,
  output logic [AW-1:0] mem_adrin,
  output logic [AW-1:0] mem_adrout,
  output logic          mem_canWr,
  output logic          mem_canRd,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          owner,
  output logic [7:0]    conflicts
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [7:0]    conflicts_q, conflicts_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] mem_in_q, mem_in_d;
  logic [AW-1:0] mem_adrin_q, mem_adrin_d;
  logic [AW-1:0] mem_adrout_q, mem_adrout_d;

  logic pick_gnt, pick_valid, pick_conflict;
  logic gnt_we, rd_last;

  nr_rr_pick2 u_pick (
    .req0     (f_req),
    .req1     (d_req),
    .last     (owner_q),
    .gnt      (pick_gnt),
    .valid    (pick_valid),
    .conflict (pick_conflict)
  );

  // Fetch port is read-only, so only a data grant can become a write
  assign gnt_we  = (pick_gnt == OWN_DATA) & d_we;
  assign rd_last = (rd_cnt_q == CW'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      conflicts_q  <= '0;
      rd_cnt_q     <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_in_q     <= '0;
      mem_adrin_q  <= '0;
      mem_adrout_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      conflicts_q  <= conflicts_d;
      rd_cnt_q     <= rd_cnt_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_in_q     <= mem_in_d;
      mem_adrin_q  <= mem_adrin_d;
      mem_adrout_q <= mem_adrout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = gnt_we ? WRITE : READ;
      WRITE:   state_d = ACK;
      READ:    if (rd_last) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    conflicts_d  = conflicts_q;
    rd_cnt_d     = rd_cnt_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_in_d     = mem_in_q;
    mem_adrin_d  = mem_adrin_q;
    mem_adrout_d = mem_adrout_q;
    if (state_q == IDLE) begin
      if (pick_conflict && conflicts_q != 8'hFF) conflicts_d = conflicts_q + 8'd1;
      if (pick_valid) begin
        owner_d = pick_gnt;
        if (gnt_we) begin
          mem_adrin_d = d_adr;
          mem_in_d    = d_wdata;
        end else begin
          mem_adrout_d = (pick_gnt == OWN_DATA) ? d_adr : f_adr;
        end
      end
    end else if (state_q == READ) begin
      if (rd_last) begin
        rd_cnt_d = '0;
        if (owner_q == OWN_DATA) d_rdata_d = mem_out;
        else                     f_rdata_d = mem_out;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    mem_canWr  = (state_q == WRITE);
    mem_canRd  = (state_q == READ);
    f_ack      = (state_q == ACK) && (owner_q == OWN_FETCH);
    d_ack      = (state_q == ACK) && (owner_q == OWN_DATA);
    busy       = (state_q != IDLE);
    owner      = owner_q;
    conflicts  = conflicts_q;
    f_rdata    = f_rdata_q;
    d_rdata    = d_rdata_q;
    mem_in     = mem_in_q;
    mem_adrin  = mem_adrin_q;
    mem_adrout = mem_adrout_q;
  end

endmodule

// File: tb/tb_nr_mem_arbiter.sv
// tb/tb_nr_mem_arbiter.sv - scoreboard bench for nr_mem_arbiter
module tb_nr_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RD_LAT = 1
  logic       clr, f_req, f_ack, d_req, d_we, d_ack, mem_canWr, mem_canRd, busy, owner;
  logic [7:0] f_adr, f_rdata, d_adr, d_wdata, d_rdata, mem_in, mem_adrin, mem_adrout, mem_out, conflicts;

  // Second instance, RD_LAT = 3, used for abort-in-read
  logic       clr3, f_req3, f_ack3, d_ack3, mem_canWr3, mem_canRd3, busy3, owner3;
  logic [7:0] f_adr3, f_rdata3, d_rdata3, mem_in3, mem_adrin3, mem_adrout3, conflicts3;

  nr_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut (
    .clk(clk), .clr(clr),
    .f_req(f_req), .f_adr(f_adr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_in(mem_in), .mem_adrin(mem_adrin), .mem_adrout(mem_adrout),
    .mem_canWr(mem_canWr), .mem_canRd(mem_canRd), .mem_out(mem_out),
    .busy(busy), .owner(owner), .conflicts(conflicts)
  );

  nr_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .clr(clr3),
    .f_req(f_req3), .f_adr(f_adr3), .f_rdata(f_rdata3), .f_ack(f_ack3),
    .d_req(1'b0), .d_we(1'b0), .d_adr(8'h00), .d_wdata(8'h00), .d_rdata(d_rdata3), .d_ack(d_ack3),
    .mem_in(mem_in3), .mem_adrin(mem_adrin3), .mem_adrout(mem_adrout3),
    .mem_canWr(mem_canWr3), .mem_canRd(mem_canRd3), .mem_out(8'hEE),
    .busy(busy3), .owner(owner3), .conflicts(conflicts3)
  );

  // RAM model: unwritten locations read as adr ^ 0x39 (so RAM[5] = 0x3C)
  bit [7:0]   ram [256];
  bit [255:0] wr_v;
  bit         wr3_seen;
  always @(posedge clk) begin
    if (mem_canWr) begin
      ram[mem_adrin]  <= mem_in;
      wr_v[mem_adrin] <= 1'b1;
    end
    if (mem_canWr3) wr3_seen <= 1'b1;
  end
  assign mem_out = wr_v[mem_adrout] ? ram[mem_adrout] : (mem_adrout ^ 8'h39);

  typedef struct {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic rd, input logic [7:0] data);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops the next expected transaction
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] got;
    if (!clr && (f_ack || d_ack)) begin
      checks++;
      if (f_ack && d_ack) begin
        errors++;
        $display("FAIL dual_ack: f_ack=1 d_ack=1 expected only one");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: ack on port %0d with nothing expected", d_ack);
      end else begin
        e = sb_q.pop_front();
        got = d_ack ? d_rdata : f_rdata;
        if (d_ack != e.port) begin
          errors++;
          $display("FAIL sb_port: ack port %0d expected %0d", d_ack, e.port);
        end else if (e.rd && got !== e.data) begin
          errors++;
          $display("FAIL sb_rdata: port %0d got %0h expected %0h", e.port, got, e.data);
        end
      end
    end
    if (mem_canWr && mem_canRd) begin
      checks++;
      errors++;
      $display("FAIL strobes: canWr and canRd both 1 expected exclusive");
    end
  end

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack within 20 cycles expected one");
  endtask

  task automatic do_xfer(input logic port, input logic we, input logic [7:0] adr,
                         input logic [7:0] wd, input logic [7:0] exp_data);
    bit ok;
    push_exp(port, !we, exp_data);
    if (port) begin
      d_we = we; d_adr = adr; d_wdata = wd; d_req = 1'b1;
    end else begin
      f_adr = adr; f_req = 1'b1;
    end
    wait_ack(ok);
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    bit ok;
    bit seen;
    clr = 1'b1; clr3 = 1'b1;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    f_adr = 8'h11; d_adr = 8'h22; d_wdata = 8'h33;
    f_req3 = 1'b0; f_adr3 = 8'h00;

    // Reset with both requests high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_strobes", {mem_canWr, mem_canRd}, 0);
    chk("rst_acks", {f_ack, d_ack}, 0);
    chk("rst_rdata", {f_rdata, d_rdata}, 0);
    chk("rst_mem_addr_data", {mem_in, mem_adrin, mem_adrout}, 0);
    chk("rst_conflicts", conflicts, 0);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    clr = 1'b0; clr3 = 1'b0;

    // Fetch read RAM[5] with cycle-exact latency
    @(negedge clk);
    push_exp(1'b0, 1'b1, 8'h3C);
    f_adr = 8'd5; f_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("frd_t1_canRd", mem_canRd, 1);
    chk("frd_t1_adrout", mem_adrout, 5);
    chk("frd_t1_canWr", mem_canWr, 0);
    @(posedge clk);
    @(negedge clk);
    chk("frd_t2_f_ack", f_ack, 1);
    chk("frd_t2_f_rdata", f_rdata, 8'h3C);
    chk("frd_t2_d_ack", d_ack, 0);
    f_req = 1'b0;

    // Data write 0xA5 to address 9
    @(negedge clk);
    push_exp(1'b1, 1'b0, 8'h00);
    d_we = 1'b1; d_adr = 8'd9; d_wdata = 8'hA5; d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("dwr_t1_canWr", mem_canWr, 1);
    chk("dwr_t1_adrin", mem_adrin, 9);
    chk("dwr_t1_in", mem_in, 8'hA5);
    chk("dwr_t1_canRd", mem_canRd, 0);
    @(posedge clk);
    @(negedge clk);
    chk("dwr_t2_canWr", mem_canWr, 0);
    chk("dwr_t2_d_ack", d_ack, 1);
    d_req = 1'b0; d_we = 1'b0;

    do_xfer(1'b0, 1'b0, 8'd9, 8'h00, 8'hA5);
    chk("d_rdata_held", d_rdata, 8'h00);
    do_xfer(1'b1, 1'b0, 8'd5, 8'h00, 8'h3C);
    chk("f_rdata_held", f_rdata, 8'hA5);
    chk("adrin_held", mem_adrin, 9);

    // Continuous conflict: fetch, data, fetch, data
    clr_pulse();
    f_adr = 8'd5; d_adr = 8'd9; d_we = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(i[0], 1'b1, i[0] ? 8'hA5 : 8'h3C);
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ok);
      if (ok) begin
        chk("rr_conflicts", conflicts, i + 1);
        chk("rr_owner", owner, i % 2);
      end
    end
    f_req = 1'b0; d_req = 1'b0;

    // 300 back-to-back conflicts: counter saturates, grants alternate
    clr_pulse();
    for (int i = 0; i < 300; i++) push_exp(i[0], 1'b1, i[0] ? 8'hA5 : 8'h3C);
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_ack(ok);
      if (!ok) break;
    end
    chk("sat_conflicts", conflicts, 255);
    f_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    // RD_LAT=3: clr during second READ cycle aborts without ack
    @(negedge clk);
    f_adr3 = 8'd7; f_req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rd1_canRd", mem_canRd3, 1);
    chk("abort_rd1_adrout", mem_adrout3, 7);
    @(posedge clk);
    @(negedge clk);
    chk("abort_rd2_canRd", mem_canRd3, 1);
    clr3 = 1'b1; f_req3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy3, 0);
    chk("abort_canRd", mem_canRd3, 0);
    chk("abort_ack", {f_ack3, d_ack3}, 0);
    chk("abort_rdata", f_rdata3, 0);
    clr3 = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (f_ack3 || d_ack3) seen = 1'b1;
    end
    chk("abort_no_late_ack", seen, 0);
    chk("abort_never_wrote", wr3_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
